mnist_csr_bank: RTL and testbench

Parametrised memory-mapped control/status register bank between the bus slave port and a compute core (e.g. the NN inference engine). It holds IN_WORDS writable operand words and OUT_WORDS read-only result words, and issues a one-cycle start pulse to the core. It tracks busy/done/error status with a sticky, write-1-to-clear DONE flag and an interrupt output, and locks the operands while the core is running.

---
 rtl/mnist_csr_bank_if.sv | 21 ++
 rtl/mnist_csr_bank.sv | 137 +++++++++++++
 tb/tb_mnist_csr_bank.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mnist_csr_bank_if.sv
// rtl/mnist_csr_bank_if.sv - register bus between a bus master and the mnist CSR bank
interface mnist_csr_bank_if #(
    parameter int ADDR_W = 6
);
    logic              W;
    logic              R;
    logic [ADDR_W-1:0] Addr;
    logic [3:0]        Byte_En;
    logic [31:0]       Write_Data;
    logic [31:0]       Read_Data;

    modport master (
        output W, R, Addr, Byte_En, Write_Data,
        input  Read_Data
    );

    modport slave (
        input  W, R, Addr, Byte_En, Write_Data,
        output Read_Data
    );
endinterface

// File: rtl/mnist_csr_bank.sv
// rtl/mnist_csr_bank.sv - operand/result CSR bank with start/done handshake for a compute core
module mnist_csr_bank #(
    parameter int IN_WORDS  = 4,
    parameter int OUT_WORDS = 4,
    parameter int ADDR_W    = 6
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    mnist_csr_bank_if.slave          Bus,
    output logic [32*IN_WORDS-1:0]   Operand,
    input  logic [32*OUT_WORDS-1:0]  Result,
    output logic                     Start,
    input  logic                     Done,
    output logic                     Irq
);
    localparam int CTRL_IDX   = IN_WORDS + OUT_WORDS;
    localparam int STATUS_IDX = IN_WORDS + OUT_WORDS + 1;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] opnd_q [IN_WORDS];
    logic [31:0] res_q  [OUT_WORDS];
    logic        irq_en_q;
    logic        done_q;
    logic        err_q;
    logic        start_q;
    logic [31:0] rdata_q;

    logic [IN_WORDS-1:0] sel_opnd;
    logic                sel_ctrl;
    logic                sel_status;
    logic                wr_opnd;
    logic                wr_ctrl;
    logic                wr_status;
    logic                busy;
    logic                done_acc;
    logic                start_d;
    logic                start_err;
    logic                err_set;
    logic [31:0]         rd_mux;

    always_comb begin
        sel_opnd = '0;
        for (int i = 0; i < IN_WORDS; i++) begin
            if (Bus.Addr == ADDR_W'(i)) sel_opnd[i] = 1'b1;
        end
        sel_ctrl   = (Bus.Addr == ADDR_W'(CTRL_IDX));
        sel_status = (Bus.Addr == ADDR_W'(STATUS_IDX));
    end

    // CTRL and STATUS only carry bits in the low byte lane
    assign wr_opnd   = Bus.W & (|sel_opnd);
    assign wr_ctrl   = Bus.W & sel_ctrl & Bus.Byte_En[0];
    assign wr_status = Bus.W & sel_status & Bus.Byte_En[0];

    assign busy     = (state_q == ST_BUSY);
    assign done_acc = Done & busy;

    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        start_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_ctrl && Bus.Write_Data[0]) begin
                    state_d = ST_BUSY;
                    start_d = 1'b1;
                end
            end
            ST_BUSY: begin
                // a START colliding with Done is still rejected; Done wins
                if (wr_ctrl && Bus.Write_Data[0]) start_err = 1'b1;
                if (Done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign err_set = start_err | (wr_opnd & busy);

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < IN_WORDS; i++) begin
            if (Bus.Addr == ADDR_W'(i)) rd_mux = opnd_q[i];
        end
        for (int j = 0; j < OUT_WORDS; j++) begin
            if (Bus.Addr == ADDR_W'(IN_WORDS + j)) rd_mux = res_q[j];
        end
        if (sel_ctrl)   rd_mux = {30'b0, irq_en_q, 1'b0};
        if (sel_status) rd_mux = {29'b0, err_q, done_q, busy};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            for (int i = 0; i < IN_WORDS; i++)  opnd_q[i] <= '0;
            for (int j = 0; j < OUT_WORDS; j++) res_q[j]  <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            if (wr_ctrl) irq_en_q <= Bus.Write_Data[1];
            // set beats write-1-to-clear when both land on the same edge
            done_q <= done_acc | (done_q & ~(wr_status & Bus.Write_Data[1]));
            err_q  <= err_set  | (err_q  & ~(wr_status & Bus.Write_Data[2]));
            for (int i = 0; i < IN_WORDS; i++) begin
                if (Bus.W && sel_opnd[i] && !busy) begin
                    for (int b = 0; b < 4; b++) begin
                        if (Bus.Byte_En[b]) opnd_q[i][8*b +: 8] <= Bus.Write_Data[8*b +: 8];
                    end
                end
            end
            if (done_acc) begin
                for (int j = 0; j < OUT_WORDS; j++) begin
                    res_q[j] <= Result[32*(OUT_WORDS-1-j) +: 32];
                end
            end
            if (Bus.R) rdata_q <= rd_mux;
        end
    end

    for (genvar g = 0; g < IN_WORDS; g++) begin : g_operand
        assign Operand[32*(IN_WORDS-1-g) +: 32] = opnd_q[g];
    end

    assign Bus.Read_Data = rdata_q;
    assign Start         = start_q;
    assign Irq           = done_q & irq_en_q;
endmodule

// File: tb/tb_mnist_csr_bank.sv
// tb/tb_mnist_csr_bank.sv - two-configuration bench for mnist_csr_bank against a behavioural model
module tb_mnist_csr_bank;
    logic         Clk = 1'b0;
    logic         Reset_n = 1'b1;
    logic         W = 1'b0;
    logic         R = 1'b0;
    logic [5:0]   Addr = '0;
    logic [3:0]   Byte_En = '0;
    logic [31:0]  Write_Data = '0;
    logic         Done = 1'b0;
    logic [319:0] res_bus = '0;

    logic [127:0] operand0;
    logic [31:0]  operand1;
    logic         start0, start1, irq0, irq1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    mnist_csr_bank_if #(.ADDR_W(6)) bus0 ();
    mnist_csr_bank_if #(.ADDR_W(4)) bus1 ();

    assign bus0.W = W;            assign bus1.W = W;
    assign bus0.R = R;            assign bus1.R = R;
    assign bus0.Addr = Addr;      assign bus1.Addr = Addr[3:0];
    assign bus0.Byte_En = Byte_En;       assign bus1.Byte_En = Byte_En;
    assign bus0.Write_Data = Write_Data; assign bus1.Write_Data = Write_Data;

    mnist_csr_bank #(.IN_WORDS(4), .OUT_WORDS(4), .ADDR_W(6)) dut0 (
        .Clk(Clk), .Reset_n(Reset_n), .Bus(bus0), .Operand(operand0),
        .Result(res_bus[127:0]), .Start(start0), .Done(Done), .Irq(irq0)
    );

    mnist_csr_bank #(.IN_WORDS(1), .OUT_WORDS(10), .ADDR_W(4)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .Bus(bus1), .Operand(operand1),
        .Result(res_bus), .Start(start1), .Done(Done), .Irq(irq1)
    );

    // behavioural model: one register file per configuration
    int inw[2]   = '{4, 1};
    int outw[2]  = '{4, 10};
    int amask[2] = '{63, 15};
    logic [31:0] m_opnd [2][16];
    logic [31:0] m_res  [2][16];
    logic [31:0] m_rd   [2];
    bit m_irqen[2], m_busy[2], m_done[2], m_err[2], m_start[2];

    function automatic logic [31:0] m_read(int c, int a);
        int cc = inw[c] + outw[c];
        if (a < inw[c]) return m_opnd[c][a];
        if (a < cc) return m_res[c][a - inw[c]];
        if (a == cc) return {30'b0, m_irqen[c], 1'b0};
        if (a == cc + 1) return {29'b0, m_err[c], m_done[c], m_busy[c]};
        return 32'h0;
    endfunction

    task automatic model_edge(int c);
        int a, cc;
        logic [31:0] pre;
        bit dacc, sacc, eset, dclr, eclr;
        a = int'(Addr) & amask[c];
        cc = inw[c] + outw[c];
        pre = m_read(c, a);
        dacc = Done && m_busy[c];
        sacc = 0; eset = 0; dclr = 0; eclr = 0;
        if (W) begin
            if (a < inw[c]) begin
                if (m_busy[c]) eset = 1;
                else for (int b = 0; b < 4; b++)
                    if (Byte_En[b]) m_opnd[c][a][8*b +: 8] = Write_Data[8*b +: 8];
            end else if (a == cc && Byte_En[0]) begin
                m_irqen[c] = Write_Data[1];
                if (Write_Data[0]) begin
                    if (m_busy[c]) eset = 1;
                    else sacc = 1;
                end
            end else if (a == cc + 1 && Byte_En[0]) begin
                dclr = Write_Data[1];
                eclr = Write_Data[2];
            end
        end
        if (dacc) begin
            for (int j = 0; j < outw[c]; j++) m_res[c][j] = res_bus[32*(outw[c]-1-j) +: 32];
            m_busy[c] = 0;
        end
        if (sacc) m_busy[c] = 1;
        m_done[c]  = dacc | (m_done[c] & !dclr);
        m_err[c]   = eset | (m_err[c] & !eclr);
        m_start[c] = sacc;
        if (R) m_rd[c] = pre;
    endtask

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < 16; k++) begin
                    m_opnd[c][k] = '0;
                    m_res[c][k]  = '0;
                end
                m_rd[c] = '0;
                m_irqen[c] = 0; m_busy[c] = 0; m_done[c] = 0; m_err[c] = 0; m_start[c] = 0;
            end
        end else begin
            model_edge(0);
            model_edge(1);
        end
    end

    function automatic logic [127:0] exp_operand(int c);
        logic [127:0] r = '0;
        for (int i = 0; i < inw[c]; i++) r[32*(inw[c]-1-i) +: 32] = m_opnd[c][i];
        return r;
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all();
        check("rd0", {96'b0, bus0.Read_Data}, {96'b0, m_rd[0]});
        check("operand0", operand0, exp_operand(0));
        check("start0", {127'b0, start0}, {127'b0, m_start[0]});
        check("irq0", {127'b0, irq0}, {127'b0, m_done[0] & m_irqen[0]});
        check("rd1", {96'b0, bus1.Read_Data}, {96'b0, m_rd[1]});
        check("operand1", {96'b0, operand1}, exp_operand(1));
        check("start1", {127'b0, start1}, {127'b0, m_start[1]});
        check("irq1", {127'b0, irq1}, {127'b0, m_done[1] & m_irqen[1]});
    endtask

    task automatic tick();
        @(negedge Clk);
        check_all();
    endtask

    task automatic bus_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        W = 1'b1; Addr = a; Write_Data = d; Byte_En = be;
        tick();
        W = 1'b0;
    endtask

    task automatic bus_rd(input logic [5:0] a);
        R = 1'b1; Addr = a;
        tick();
        R = 1'b0;
    endtask

    task automatic pulse_done();
        Done = 1'b1;
        tick();
        Done = 1'b0;
    endtask

    task automatic lit(string name, logic [31:0] act, logic [31:0] exp);
        check(name, {96'b0, act}, {96'b0, exp});
    endtask

    initial begin
        #2 Reset_n = 1'b0;
        repeat (3) tick();
        Reset_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            bus_rd(6'(a));
            lit("idle_read", bus0.Read_Data, 32'h0);
        end
        lit("idle_start", {31'b0, start0}, 32'h0);
        lit("idle_irq", {31'b0, irq0}, 32'h0);

        bus_wr(6'd1, 32'hAABBCCDD, 4'b1111);
        bus_wr(6'd1, 32'h11223344, 4'b0101);
        bus_rd(6'd1);
        lit("be_read", bus0.Read_Data, 32'hAA22CC44);
        lit("be_operand", operand0[95:64], 32'hAA22CC44);

        res_bus[127:0] = {32'h1, 32'h2, 32'h3, 32'h4};
        bus_wr(6'd8, 32'h3, 4'hF);
        lit("start_hi", {31'b0, start0}, 32'h1);
        bus_rd(6'd9);
        lit("start_lo", {31'b0, start0}, 32'h0);
        lit("status_busy", bus0.Read_Data, 32'h1);
        pulse_done();
        bus_rd(6'd9);
        lit("status_done", bus0.Read_Data, 32'h2);
        lit("irq_set", {31'b0, irq0}, 32'h1);
        bus_rd(6'd4);
        lit("res0", bus0.Read_Data, 32'h1);
        bus_rd(6'd7);
        lit("res3", bus0.Read_Data, 32'h4);
        bus_wr(6'd9, 32'h2, 4'hF);
        bus_rd(6'd9);
        lit("status_w1c", bus0.Read_Data, 32'h0);
        lit("irq_clr", {31'b0, irq0}, 32'h0);

        bus_wr(6'd8, 32'h3, 4'hF);
        bus_wr(6'd0, 32'hDEADBEEF, 4'hF);
        bus_rd(6'd0);
        lit("lock_opnd", bus0.Read_Data, 32'h0);
        bus_rd(6'd9);
        lit("lock_status", bus0.Read_Data, 32'h5);
        bus_wr(6'd8, 32'h1, 4'hF);
        lit("restart_rej", {31'b0, start0}, 32'h0);
        bus_wr(6'd9, 32'h4, 4'hF);
        bus_rd(6'd9);
        lit("err_w1c", bus0.Read_Data, 32'h1);

        W = 1'b1; Addr = 6'd8; Write_Data = 32'h1; Byte_En = 4'hF; Done = 1'b1;
        tick();
        W = 1'b0; Done = 1'b0;
        bus_rd(6'd9);
        lit("collision", bus0.Read_Data, 32'h6);
        res_bus[127:0] = {32'h9, 32'h9, 32'h9, 32'h9};
        pulse_done();
        bus_rd(6'd4);
        lit("stray_res", bus0.Read_Data, 32'h1);
        bus_rd(6'd9);
        lit("stray_status", bus0.Read_Data, 32'h6);

        bus_wr(6'd9, 32'h6, 4'hF);
        bus_wr(6'd8, 32'h1, 4'hF);
        Reset_n = 1'b0;
        repeat (3) tick();
        Reset_n = 1'b1;
        pulse_done();
        bus_rd(6'd9);
        lit("rst_status", bus0.Read_Data, 32'h0);
        bus_rd(6'd1);
        lit("rst_opnd", bus0.Read_Data, 32'h0);

        bus_wr(6'd0, 32'h12345678, 4'hF);
        lit("cfg1_operand", operand1, 32'h12345678);
        bus_wr(6'd11, 32'h1, 4'hF);
        lit("cfg1_start", {31'b0, start1}, 32'h1);
        bus_rd(6'd12);
        lit("cfg1_busy", bus1.Read_Data, 32'h1);
        pulse_done();
        bus_rd(6'd12);
        lit("cfg1_done", bus1.Read_Data, 32'h2);
        bus_rd(6'd13);
        lit("cfg1_hole", bus1.Read_Data, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            W = ($urandom % 100) < 35;
            R = $urandom % 2;
            case ($urandom % 4)
                0: Addr = 6'd8;
                1: Addr = ($urandom % 2) ? 6'd9 : (($urandom % 2) ? 6'd11 : 6'd12);
                default: Addr = 6'($urandom % 18);
            endcase
            Write_Data = $urandom;
            Byte_En = ($urandom % 2) ? 4'hF : 4'($urandom);
            Done = ($urandom % 100) < 15;
            for (int k = 0; k < 10; k++) res_bus[32*k +: 32] = $urandom;
            Reset_n = ($urandom % 500) != 0;
            tick();
        end
        W = 1'b0; R = 1'b0; Done = 1'b0; Reset_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
